// File: rtl/fetch_pc_unit.sv
// Fetch front end: owns the PC, issues single-beat imem reads, presents {pc_out, instr_out}.
// Optional feature macro: FETCH_MISALIGN_EN (one-cycle pulse on a misaligned redirect target).
module fetch_pc_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned PC_STEP  = 4,
   parameter int unsigned TIMEOUT  = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic        fetch_valid,
   output logic [31:0] pc_out,
   output logic [31:0] instr_out,
   output logic        fetch_timeout,
   output logic        fetch_misalign
);

   localparam logic [31:0] NOP       = 32'h0000_0013;
   localparam logic [31:0] STEP_W    = 32'(PC_STEP);
   localparam logic [7:0]  TIMEOUT_W = 8'(TIMEOUT);

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_PRESENT,
      S_HOLD
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic        squash_q, squash_d;
   logic [7:0]  wait_cnt_q, wait_cnt_d;
   logic        imem_req_q, imem_req_d;
   logic [31:0] imem_addr_q, imem_addr_d;
   logic        fetch_valid_q, fetch_valid_d;
   logic [31:0] pc_out_q, pc_out_d;
   logic [31:0] instr_out_q, instr_out_d;
   logic        fetch_timeout_q, fetch_timeout_d;
   logic [31:0] redir_target;

   // Redirect targets are always word-aligned; the low bits only feed the misalign flag.
   assign redir_target = {redirect_pc[31:2], 2'b00};

   always_comb begin
      state_d         = state_q;
      pc_d            = pc_q;
      squash_d        = squash_q;
      wait_cnt_d      = wait_cnt_q;
      fetch_valid_d   = fetch_valid_q;
      pc_out_d        = pc_out_q;
      instr_out_d     = instr_out_q;
      fetch_timeout_d = fetch_timeout_q;

      case (state_q)
         S_IDLE: begin
            if (redirect) begin
               pc_d = redir_target;
            end
            fetch_valid_d = 1'b0;
            state_d       = S_REQ;
         end

         S_REQ: begin
            wait_cnt_d = 8'd0;
            if (redirect) begin
               // The request at the old pc is already out; its response must be dropped.
               pc_d     = redir_target;
               squash_d = 1'b1;
               state_d  = S_REQ;
            end else begin
               state_d = S_WAIT;
            end
         end

         S_WAIT: begin
            wait_cnt_d = (wait_cnt_q == 8'hFF) ? 8'hFF : wait_cnt_q + 8'd1;
            if (wait_cnt_d == TIMEOUT_W) begin
               fetch_timeout_d = 1'b1;
            end
            if (imem_rvalid && (squash_q || redirect)) begin
               squash_d = 1'b0;
               if (redirect) begin
                  pc_d = redir_target;
               end
               state_d = S_REQ;
            end else if (imem_rvalid) begin
               pc_out_d      = pc_q;
               instr_out_d   = imem_rdata;
               fetch_valid_d = 1'b1;
               state_d       = S_PRESENT;
            end else if (redirect) begin
               pc_d     = redir_target;
               squash_d = 1'b1;
            end
         end

         S_PRESENT, S_HOLD: begin
            if (redirect) begin
               pc_d          = redir_target;
               fetch_valid_d = 1'b0;
               state_d       = S_REQ;
            end else if (stall) begin
               state_d = S_HOLD;
            end else begin
               fetch_valid_d = 1'b0;
               pc_d          = pc_q + STEP_W;
               state_d       = S_REQ;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Request outputs are registered so they line up with the cycle spent in REQ.
      imem_req_d  = (state_d == S_REQ);
      imem_addr_d = imem_req_d ? pc_d : imem_addr_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= S_IDLE;
         pc_q            <= RESET_PC;
         squash_q        <= 1'b0;
         wait_cnt_q      <= 8'd0;
         imem_req_q      <= 1'b0;
         imem_addr_q     <= 32'h0000_0000;
         fetch_valid_q   <= 1'b0;
         pc_out_q        <= 32'h0000_0000;
         instr_out_q     <= NOP;
         fetch_timeout_q <= 1'b0;
      end else begin
         state_q         <= state_d;
         pc_q            <= pc_d;
         squash_q        <= squash_d;
         wait_cnt_q      <= wait_cnt_d;
         imem_req_q      <= imem_req_d;
         imem_addr_q     <= imem_addr_d;
         fetch_valid_q   <= fetch_valid_d;
         pc_out_q        <= pc_out_d;
         instr_out_q     <= instr_out_d;
         fetch_timeout_q <= fetch_timeout_d;
      end
   end

   assign imem_req      = imem_req_q;
   assign imem_addr     = imem_addr_q;
   assign fetch_valid   = fetch_valid_q;
   assign pc_out        = pc_out_q;
   assign instr_out     = instr_out_q;
   assign fetch_timeout = fetch_timeout_q;

`ifdef FETCH_MISALIGN_EN
   logic fetch_misalign_q, fetch_misalign_d;

   always_comb begin
      fetch_misalign_d = redirect & (|redirect_pc[1:0]);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_misalign_q <= 1'b0;
      end else begin
         fetch_misalign_q <= fetch_misalign_d;
      end
   end

   assign fetch_misalign = fetch_misalign_q;
`else
   logic unused_lsb;
   assign unused_lsb     = ^redirect_pc[1:0];
   assign fetch_misalign = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed cycle-by-cycle bench for fetch_pc_unit: vector table plus timeout/misalign/reset sequences.
// Honours FETCH_MISALIGN_EN for the expected misalign pulse.
module tb_fetch_pc_unit;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk;
   logic        rst;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        fetch_valid;
   logic [31:0] pc_out;
   logic [31:0] instr_out;
   logic        fetch_timeout;
   logic        fetch_misalign;

   int checks;
   int failures;

   fetch_pc_unit dut (
      .clk            (clk),
      .rst            (rst),
      .stall          (stall),
      .redirect       (redirect),
      .redirect_pc    (redirect_pc),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_rvalid    (imem_rvalid),
      .imem_rdata     (imem_rdata),
      .fetch_valid    (fetch_valid),
      .pc_out         (pc_out),
      .instr_out      (instr_out),
      .fetch_timeout  (fetch_timeout),
      .fetch_misalign (fetch_misalign)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs applied for one cycle; expected outputs are those seen just after that edge.
   typedef struct {
      logic        stall;
      logic        redir;
      logic [31:0] rpc;
      logic        rv;
      logic [31:0] rd;
      logic        req;
      logic [31:0] addr;
      logic        fv;
      logic [31:0] pco;
      logic [31:0] ins;
   } vec_t;

   localparam int NV = 42;
   vec_t vecs[NV];

   function automatic vec_t mk(input logic s, input logic r, input logic [31:0] rp,
                               input logic v, input logic [31:0] d, input logic q,
                               input logic [31:0] a, input logic f, input logic [31:0] p,
                               input logic [31:0] i);
      vec_t t;
      t.stall = s; t.redir = r; t.rpc = rp; t.rv = v; t.rd = d;
      t.req = q; t.addr = a; t.fv = f; t.pco = p; t.ins = i;
      return t;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
      imem_rvalid = 1'b0; imem_rdata = 32'h0;
   endtask

   initial begin
      logic exp_mis;
      checks   = 0;
      failures = 0;
      rst      = 1'b1;
      clear_inputs();

      //              stall redir rpc            rv rdata          req addr           fv pc_out         instr
      vecs[0]  = mk(0, 0, 32'h0,          0, 32'h0,          1, 32'h0,          0, 32'h0,          NOP);
      vecs[1]  = mk(0, 0, 32'h0,          0, 32'h0,          0, 32'h0,          0, 32'h0,          NOP);
      vecs[2]  = mk(0, 0, 32'h0,          1, 32'hA,          0, 32'h0,          1, 32'h0,          32'hA);
      vecs[3]  = mk(0, 0, 32'h0,          0, 32'h0,          1, 32'h4,          0, 32'h0,          32'hA);
      vecs[4]  = mk(0, 0, 32'h0,          0, 32'h0,          0, 32'h4,          0, 32'h0,          32'hA);
      vecs[5]  = mk(0, 0, 32'h0,          1, 32'hB,          0, 32'h4,          1, 32'h4,          32'hB);
      vecs[6]  = mk(0, 0, 32'h0,          0, 32'h0,          1, 32'h8,          0, 32'h4,          32'hB);
      vecs[7]  = mk(0, 0, 32'h0,          0, 32'h0,          0, 32'h8,          0, 32'h4,          32'hB);
      vecs[8]  = mk(0, 0, 32'h0,          1, 32'hC,          0, 32'h8,          1, 32'h8,          32'hC);
      vecs[9]  = mk(1, 0, 32'h0,          0, 32'h0,          0, 32'h8,          1, 32'h8,          32'hC);
      vecs[10] = mk(1, 0, 32'h0,          0, 32'h0,          0, 32'h8,          1, 32'h8,          32'hC);
      vecs[11] = mk(1, 0, 32'h0,          0, 32'h0,          0, 32'h8,          1, 32'h8,          32'hC);
      vecs[12] = mk(0, 0, 32'h0,          0, 32'h0,          1, 32'hC,          0, 32'h8,          32'hC);
      vecs[13] = mk(0, 0, 32'h0,          0, 32'h0,          0, 32'hC,          0, 32'h8,          32'hC);
      vecs[14] = mk(0, 1, 32'h100,        0, 32'h0,          0, 32'hC,          0, 32'h8,          32'hC);
      vecs[15] = mk(0, 0, 32'h0,          0, 32'h0,          0, 32'hC,          0, 32'h8,          32'hC);
      vecs[16] = mk(0, 0, 32'h0,          1, 32'hDEAD,       1, 32'h100,        0, 32'h8,          32'hC);
      vecs[17] = mk(0, 0, 32'h0,          0, 32'h0,          0, 32'h100,        0, 32'h8,          32'hC);
      vecs[18] = mk(0, 0, 32'h0,          1, 32'h111,        0, 32'h100,        1, 32'h100,        32'h111);
      vecs[19] = mk(0, 0, 32'h0,          0, 32'h0,          1, 32'h104,        0, 32'h100,        32'h111);
      vecs[20] = mk(0, 0, 32'h0,          0, 32'h0,          0, 32'h104,        0, 32'h100,        32'h111);
      vecs[21] = mk(0, 1, 32'hFFFF_FFFC,  1, 32'hBAD,        1, 32'hFFFF_FFFC,  0, 32'h100,        32'h111);
      vecs[22] = mk(0, 0, 32'h0,          0, 32'h0,          0, 32'hFFFF_FFFC,  0, 32'h100,        32'h111);
      vecs[23] = mk(0, 0, 32'h0,          1, 32'h222,        0, 32'hFFFF_FFFC,  1, 32'hFFFF_FFFC,  32'h222);
      vecs[24] = mk(0, 0, 32'h0,          0, 32'h0,          1, 32'h0,          0, 32'hFFFF_FFFC,  32'h222);
      vecs[25] = mk(0, 0, 32'h0,          0, 32'h0,          0, 32'h0,          0, 32'hFFFF_FFFC,  32'h222);
      vecs[26] = mk(0, 0, 32'h0,          1, 32'h333,        0, 32'h0,          1, 32'h0,          32'h333);
      vecs[27] = mk(1, 0, 32'h0,          0, 32'h0,          0, 32'h0,          1, 32'h0,          32'h333);
      vecs[28] = mk(1, 1, 32'h200,        0, 32'h0,          1, 32'h200,        0, 32'h0,          32'h333);
      vecs[29] = mk(0, 1, 32'h300,        0, 32'h0,          1, 32'h300,        0, 32'h0,          32'h333);
      vecs[30] = mk(0, 0, 32'h0,          0, 32'h0,          0, 32'h300,        0, 32'h0,          32'h333);
      vecs[31] = mk(0, 0, 32'h0,          1, 32'hBAD,        1, 32'h300,        0, 32'h0,          32'h333);
      vecs[32] = mk(0, 0, 32'h0,          0, 32'h0,          0, 32'h300,        0, 32'h0,          32'h333);
      vecs[33] = mk(0, 0, 32'h0,          1, 32'h444,        0, 32'h300,        1, 32'h300,        32'h444);
      vecs[34] = mk(0, 0, 32'h0,          0, 32'h0,          1, 32'h304,        0, 32'h300,        32'h444);
      vecs[35] = mk(0, 0, 32'h0,          0, 32'h0,          0, 32'h304,        0, 32'h300,        32'h444);
      vecs[36] = mk(0, 1, 32'h400,        0, 32'h0,          0, 32'h304,        0, 32'h300,        32'h444);
      vecs[37] = mk(0, 1, 32'h500,        0, 32'h0,          0, 32'h304,        0, 32'h300,        32'h444);
      vecs[38] = mk(0, 0, 32'h0,          1, 32'hBAD,        1, 32'h500,        0, 32'h300,        32'h444);
      vecs[39] = mk(0, 0, 32'h0,          0, 32'h0,          0, 32'h500,        0, 32'h300,        32'h444);
      vecs[40] = mk(0, 0, 32'h0,          1, 32'h555,        0, 32'h500,        1, 32'h500,        32'h555);
      vecs[41] = mk(0, 0, 32'h0,          0, 32'h0,          1, 32'h504,        0, 32'h500,        32'h555);

`ifdef FETCH_MISALIGN_EN
      exp_mis = 1'b1;
`else
      exp_mis = 1'b0;
`endif

      // Reset state
      step();
      chk("rst_req", {31'b0, imem_req}, 32'h0);
      chk("rst_addr", imem_addr, 32'h0);
      chk("rst_fv", {31'b0, fetch_valid}, 32'h0);
      chk("rst_pc_out", pc_out, 32'h0);
      chk("rst_instr", instr_out, NOP);
      chk("rst_timeout", {31'b0, fetch_timeout}, 32'h0);
      chk("rst_misalign", {31'b0, fetch_misalign}, 32'h0);
      rst = 1'b0;

      for (int i = 0; i < NV; i++) begin
         stall       = vecs[i].stall;
         redirect    = vecs[i].redir;
         redirect_pc = vecs[i].rpc;
         imem_rvalid = vecs[i].rv;
         imem_rdata  = vecs[i].rd;
         step();
         chk($sformatf("v%0d_req", i), {31'b0, imem_req}, {31'b0, vecs[i].req});
         chk($sformatf("v%0d_addr", i), imem_addr, vecs[i].addr);
         chk($sformatf("v%0d_fv", i), {31'b0, fetch_valid}, {31'b0, vecs[i].fv});
         chk($sformatf("v%0d_pc_out", i), pc_out, vecs[i].pco);
         chk($sformatf("v%0d_instr", i), instr_out, vecs[i].ins);
         chk($sformatf("v%0d_timeout", i), {31'b0, fetch_timeout}, 32'h0);
         chk($sformatf("v%0d_misalign", i), {31'b0, fetch_misalign}, 32'h0);
      end
      clear_inputs();

      // Timeout: request at 0x504 is never answered for a long time
      step();
      chk("to_enter_wait_req", {31'b0, imem_req}, 32'h0);
      repeat (250) step();
      chk("to_before", {31'b0, fetch_timeout}, 32'h0);
      repeat (10) step();
      chk("to_after", {31'b0, fetch_timeout}, 32'h1);
      chk("to_still_waiting_fv", {31'b0, fetch_valid}, 32'h0);
      chk("to_no_req", {31'b0, imem_req}, 32'h0);
      imem_rvalid = 1'b1; imem_rdata = 32'h666;
      step();
      imem_rvalid = 1'b0;
      chk("to_late_fv", {31'b0, fetch_valid}, 32'h1);
      chk("to_late_pc", pc_out, 32'h504);
      chk("to_late_instr", instr_out, 32'h666);
      chk("to_sticky1", {31'b0, fetch_timeout}, 32'h1);
      repeat (3) step();
      chk("to_sticky2", {31'b0, fetch_timeout}, 32'h1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("to_rst_clear", {31'b0, fetch_timeout}, 32'h0);
      chk("to_rst_instr", instr_out, NOP);
      chk("to_rst_fv", {31'b0, fetch_valid}, 32'h0);

      // Misaligned redirect from IDLE
      redirect = 1'b1; redirect_pc = 32'h102;
      step();
      clear_inputs();
      chk("mis_req", {31'b0, imem_req}, 32'h1);
      chk("mis_addr", imem_addr, 32'h100);
      chk("mis_pulse", {31'b0, fetch_misalign}, {31'b0, exp_mis});
      step();
      chk("mis_pulse_end", {31'b0, fetch_misalign}, 32'h0);
      chk("mis_wait_req", {31'b0, imem_req}, 32'h0);

      // Reset mid-WAIT: a response arriving afterwards is ignored
      rst = 1'b1;
      step();
      rst = 1'b0;
      imem_rvalid = 1'b1; imem_rdata = 32'h777;
      step();
      imem_rvalid = 1'b0;
      chk("rmw_fv", {31'b0, fetch_valid}, 32'h0);
      chk("rmw_req", {31'b0, imem_req}, 32'h1);
      chk("rmw_addr", imem_addr, 32'h0);
      repeat (2) step();
      chk("rmw_fv_later", {31'b0, fetch_valid}, 32'h0);
      chk("rmw_instr", instr_out, NOP);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
